// File: rtl/snake_head_tracker.sv
// Snake game head/body tracker: steers the head on a 32x32 torus, keeps the body
// in a circular buffer, grows on food and flags (sticky) self-collision.
module snake_head_tracker #(
    parameter int unsigned MAX_LEN  = 16,
    parameter logic [4:0]  START_XY = 5'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       game_en,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic       grow,
    input  logic [3:0] seg_idx,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    output logic [4:0] seg_x,
    output logic [4:0] seg_y,
    output logic       seg_valid,
    output logic       step_done,
    output logic       collision
);

    localparam int unsigned PTR_W   = $clog2(MAX_LEN);
    localparam logic [4:0]  LEN_MAX = 5'(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    logic [1:0]       curDir;
    logic [1:0]       nxtDir;
    logic             growPending;
    logic [PTR_W-1:0] wrPtr;
    logic [4:0]       bufX [MAX_LEN];
    logic [4:0]       bufY [MAX_LEN];

    logic             dirLegal;
    logic [1:0]       stepDir;
    logic             growEff;
    logic             stepEn;
    logic             hit;
    logic             commit;
    logic [4:0]       candX;
    logic [4:0]       candY;
    logic [4:0]       bodyLim;
    logic [PTR_W-1:0] nextPtr;
    logic [4:0]       nextLen;
    logic [PTR_W-1:0] readAddr;
    logic             readValid;
    logic [4:0]       readX;
    logic [4:0]       readY;

    // Opposite directions differ only in bit 1, so a reversal is cur ^ 2'b10.
    always_comb begin
        dirLegal = dir_valid && (dir_in != (curDir ^ 2'b10));
        stepDir  = dirLegal ? dir_in : nxtDir;
        growEff  = growPending | grow;
        stepEn   = tick & game_en & ~collision;
        candX    = head_x;
        candY    = head_y;
        case (stepDir)
            DIR_UP:    candY = head_y - 5'd1;
            DIR_RIGHT: candX = head_x + 5'd1;
            DIR_DOWN:  candY = head_y + 5'd1;
            DIR_LEFT:  candX = head_x - 5'd1;
            default:   candX = head_x;
        endcase
    end

    // Tail leaves this step unless the snake grows, so it only counts when growing.
    always_comb begin
        bodyLim = growEff ? length : length - 5'd1;
        hit     = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((5'(PTR_W'(wrPtr - PTR_W'(i))) < bodyLim) &&
                (bufX[i] == candX) && (bufY[i] == candY)) begin
                hit = 1'b1;
            end
        end
    end

    // Segment read sees the buffer after any step committing this cycle.
    always_comb begin
        commit    = stepEn & ~hit;
        nextPtr   = commit ? PTR_W'(wrPtr + PTR_W'(1)) : wrPtr;
        nextLen   = (commit && growEff && (length != LEN_MAX)) ? length + 5'd1 : length;
        readAddr  = PTR_W'(nextPtr - PTR_W'(seg_idx));
        readValid = ({1'b0, seg_idx} < nextLen);
        if (commit && (seg_idx == 4'd0)) begin
            readX = candX;
            readY = candY;
        end else begin
            readX = bufX[readAddr];
            readY = bufY[readAddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_x      <= START_XY;
            head_y      <= START_XY;
            curDir      <= DIR_RIGHT;
            nxtDir      <= DIR_RIGHT;
            length      <= 5'd1;
            growPending <= 1'b0;
            collision   <= 1'b0;
            step_done   <= 1'b0;
            seg_x       <= 5'd0;
            seg_y       <= 5'd0;
            seg_valid   <= 1'b0;
            wrPtr       <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                bufX[i] <= START_XY;
                bufY[i] <= START_XY;
            end
        end else begin
            step_done <= stepEn;
            nxtDir    <= stepDir;
            length    <= nextLen;
            seg_valid <= readValid;
            seg_x     <= readValid ? readX : 5'd0;
            seg_y     <= readValid ? readY : 5'd0;
            if (stepEn && hit) begin
                collision <= 1'b1;
            end
            if (commit) begin
                head_x        <= candX;
                head_y        <= candY;
                curDir        <= stepDir;
                wrPtr         <= nextPtr;
                bufX[nextPtr] <= candX;
                bufY[nextPtr] <= candY;
                growPending   <= 1'b0;
            end else begin
                growPending   <= growEff;
            end
        end
    end

endmodule

// File: tb/tb_snake_head_tracker.sv
// Bench for snake_head_tracker: directed scenarios plus random play, all checked
// against a queue-based game model.
module tb_snake_head_tracker;

    localparam int MAXL  = 16;
    localparam int START = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       game_en = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic       dir_valid = 1'b0;
    logic       grow = 1'b0;
    logic [3:0] seg_idx = 4'd0;
    logic [4:0] head_x, head_y, length, seg_x, seg_y;
    logic       seg_valid, step_done, collision;

    snake_head_tracker #(.MAX_LEN(MAXL), .START_XY(5'd16)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .game_en(game_en),
        .dir_in(dir_in), .dir_valid(dir_valid), .grow(grow), .seg_idx(seg_idx),
        .head_x(head_x), .head_y(head_y), .length(length),
        .seg_x(seg_x), .seg_y(seg_y), .seg_valid(seg_valid),
        .step_done(step_done), .collision(collision)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nBad    = 0;
    int doneCnt = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nBad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Game model: body as a queue of cells, front = head.
    int mHx, mHy, mLen, mCur, mNxt;
    bit mGrow, mCol, mDone;
    int qx[$];
    int qy[$];

    function automatic int ddx(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int ddy(input int d);
        return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
    endfunction

    task automatic modelReset();
        mHx = START; mHy = START; mLen = 1; mCur = 1; mNxt = 1;
        mGrow = 0; mCol = 0; mDone = 0;
        qx = {}; qy = {};
        qx.push_front(START); qy.push_front(START);
    endtask

    task automatic modelStep(input bit t, input bit en, input bit dv, input int d, input bit g);
        bit legal, gEff, bump;
        int sd, nx, ny, lim;
        legal = dv && (d != ((mCur + 2) % 4));
        if (legal) mNxt = d;
        sd    = mNxt;
        gEff  = mGrow || g;
        mDone = 0;
        if (t && en && !mCol) begin
            mDone = 1;
            nx  = (mHx + ddx(sd) + 32) % 32;
            ny  = (mHy + ddy(sd) + 32) % 32;
            lim = gEff ? mLen : mLen - 1;
            bump = 0;
            for (int k = 0; k < lim; k++)
                if (qx[k] == nx && qy[k] == ny) bump = 1;
            if (bump) begin
                mCol  = 1;
                mGrow = gEff;
            end else begin
                qx.push_front(nx); qy.push_front(ny);
                if (qx.size() > MAXL) begin
                    void'(qx.pop_back()); void'(qy.pop_back());
                end
                mHx = nx; mHy = ny; mCur = sd;
                if (gEff && mLen < MAXL) mLen++;
                mGrow = 0;
            end
        end else begin
            mGrow = gEff;
        end
    endtask

    task automatic checkAll(input int idx);
        bit v;
        v = (idx < mLen);
        checkVal("head_x", head_x, mHx);
        checkVal("head_y", head_y, mHy);
        checkVal("length", length, mLen);
        checkVal("collision", collision, mCol);
        checkVal("step_done", step_done, mDone);
        checkVal("seg_valid", seg_valid, v);
        checkVal("seg_x", seg_x, v ? qx[idx] : 0);
        checkVal("seg_y", seg_y, v ? qy[idx] : 0);
        if (step_done) doneCnt++;
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, compare.
    task automatic cyc(input bit t, input bit en, input bit dv, input int d, input bit g);
        int idx;
        idx = $urandom_range(0, 15);
        tick = t; game_en = en; dir_valid = dv; dir_in = 2'(d); grow = g; seg_idx = 4'(idx);
        @(posedge clk);
        modelStep(t, en, dv, d, g);
        #1;
        checkAll(idx);
        tick = 0; dir_valid = 0; grow = 0;
    endtask

    task automatic stepTo(input int d, input bit g);
        cyc(1, 1, 1, d, g);
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic tickOnly(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, 0, 0, 0);
            cyc(0, 1, 0, 0, 0);
        end
    endtask

    // Reset optionally lands on top of a live tick; the step must be abandoned.
    task automatic doReset(input bit withTick);
        #2;
        tick = withTick; game_en = 1; grow = withTick;
        rst_n = 0;
        #1;
        checkVal("rst_head_x", head_x, START);
        checkVal("rst_head_y", head_y, START);
        checkVal("rst_length", length, 1);
        checkVal("rst_collision", collision, 0);
        checkVal("rst_step_done", step_done, 0);
        checkVal("rst_seg_valid", seg_valid, 0);
        checkVal("rst_seg_x", seg_x, 0);
        @(posedge clk);
        #1;
        checkVal("rst_hold_x", head_x, START);
        checkVal("rst_hold_len", length, 1);
        tick = 0; grow = 0;
        rst_n = 1;
        modelReset();
        doneCnt = 0;
    endtask

    int sx, sy;

    initial begin
        modelReset();
        @(posedge clk);
        #1;
        doReset(0);

        // three plain ticks from reset
        tickOnly(3);
        checkVal("three_ticks_x", head_x, 19);
        checkVal("three_ticks_y", head_y, 16);
        checkVal("three_ticks_len", length, 1);
        checkVal("three_ticks_done", doneCnt, 3);

        // wrap on x then on y
        doReset(0);
        tickOnly(15);
        checkVal("x_at_31", head_x, 31);
        tickOnly(1);
        checkVal("x_wrap", head_x, 0);
        stepTo(0, 0);
        tickOnly(15);
        checkVal("y_at_0", head_y, 0);
        tickOnly(1);
        checkVal("y_wrap", head_y, 31);
        checkVal("y_wrap_x", head_x, 0);

        // reversal dropped; last legal request wins
        doReset(1);
        cyc(0, 1, 1, 3, 0);
        tickOnly(1);
        checkVal("rev_drop_x", head_x, 17);
        checkVal("rev_drop_y", head_y, 16);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 2, 0);
        tickOnly(1);
        checkVal("last_wins_x", head_x, 17);
        checkVal("last_wins_y", head_y, 17);
        cyc(0, 1, 1, 0, 0);
        tickOnly(1);
        checkVal("rev_vs_cur_y", head_y, 18);

        // growth and saturation, plus game_en gating
        doReset(0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 1);
            tickOnly(1);
        end
        cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        checkVal("len_six", length, 6);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        checkVal("disabled_len", length, 6);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 0, 1);
            cyc(0, 1, 0, 0, 0);
        end
        checkVal("len_sat", length, 16);

        // closing a square with length 5 collides
        doReset(0);
        for (int i = 0; i < 4; i++) stepTo(1, 1);
        checkVal("len_five", length, 5);
        stepTo(2, 0);
        stepTo(3, 0);
        sx = head_x; sy = head_y;
        stepTo(0, 0);
        checkVal("sq_collision", collision, 1);
        checkVal("sq_hold_x", head_x, sx);
        checkVal("sq_hold_y", head_y, sy);
        checkVal("sq_hold_len", length, 5);
        tickOnly(3);
        checkVal("sq_frozen_x", head_x, sx);
        checkVal("sq_frozen_y", head_y, sy);
        doReset(0);
        checkVal("sq_cleared", collision, 0);

        // 2x2 loop: tail excluded unless growing
        for (int i = 0; i < 3; i++) stepTo(1, 1);
        for (int i = 0; i < 2; i++) begin
            stepTo(2, 0); stepTo(3, 0); stepTo(0, 0); stepTo(1, 0);
        end
        checkVal("loop_no_col", collision, 0);
        checkVal("loop_len", length, 4);
        cyc(0, 1, 0, 0, 1);
        stepTo(2, 0);
        checkVal("loop_grow_col", collision, 1);

        // random play
        for (int r = 0; r < 8; r++) begin
            doReset(r % 2 == 1);
            for (int c = 0; c < 300; c++) begin
                cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 5) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
